// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the LC-3 ALU-class control sequencers:
// FSM states, opcode and ALUK encodings, plus small decode helpers.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        DONE      = 3'd4
    } state_e;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_PASS = 2'b10;
    localparam logic [1:0] ALUK_NOT  = 2'b11;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic [1:0] aluk_of(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALUK_ADD;
            OP_AND:  return ALUK_AND;
            OP_NOT:  return ALUK_NOT;
            default: return ALUK_PASS;
        endcase
    endfunction

endpackage

// File: rtl/nzp_gen.sv
// Combinational condition-code generator: one-hot {N,Z,P} from a 16-bit value.
// Shared with the load/store sequencer.
module nzp_gen (
    input  logic [15:0] value_i,
    output logic [2:0]  nzp_o
);

    logic n_bit;
    logic z_bit;

    assign n_bit = value_i[15];
    assign z_bit = (value_i == 16'd0);
    assign nzp_o = {n_bit, z_bit, ~(n_bit | z_bit)};

endmodule

// File: rtl/alu_op_sequencer.sv
// Multicycle control FSM for LC-3 ADD/AND/NOT: decodes the captured IR, drives
// ALU and register-file controls, then commits LD_REG/LD_CC and the NZP register.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [15:0] IR,
    input  logic [15:0] ALU_OUT,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [1:0]  ALUK,
    output logic        SR2MUX,
    output logic [2:0]  SR1_SEL,
    output logic [2:0]  SR2_SEL,
    output logic [2:0]  DR_SEL,
    output logic        LD_REG,
    output logic        LD_CC,
    output logic [2:0]  NZP
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_e      state_q;
    logic [15:0] ir_q;
    logic [3:0]  exec_cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        illegal_q;
    logic [1:0]  aluk_q;
    logic        sr2mux_q;
    logic [2:0]  sr1_sel_q;
    logic [2:0]  sr2_sel_q;
    logic [2:0]  dr_sel_q;
    logic        ld_reg_q;
    logic        ld_cc_q;
    logic [2:0]  nzp_q;
    logic [2:0]  nzp_d;
    logic [3:0]  op;
    logic        ir_imm_unused;

    assign op = ir_q[15:12];
    // imm5[4:3] is consumed by the datapath's sext, never by the controller
    assign ir_imm_unused = ^ir_q[4:3];

    nzp_gen u_nzp_gen (
        .value_i (ALU_OUT),
        .nzp_o   (nzp_d)
    );

    // Outputs are registered with the value belonging to the state being entered,
    // so every control is stable for the whole cycle of its state.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            ir_q       <= 16'd0;
            exec_cnt_q <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            aluk_q     <= ALUK_PASS;
            sr2mux_q   <= 1'b0;
            sr1_sel_q  <= 3'd0;
            sr2_sel_q  <= 3'd0;
            dr_sel_q   <= 3'd0;
            ld_reg_q   <= 1'b0;
            ld_cc_q    <= 1'b0;
            nzp_q      <= 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= DECODE;
                        ir_q      <= IR;
                        busy_q    <= 1'b1;
                        dr_sel_q  <= IR[11:9];
                        sr1_sel_q <= IR[8:6];
                        sr2_sel_q <= IR[2:0];
                    end
                end
                DECODE: begin
                    if (op_is_legal(op)) begin
                        state_q    <= EXECUTE;
                        exec_cnt_q <= EXEC_LOAD;
                        aluk_q     <= aluk_of(op);
                        sr2mux_q   <= (op == OP_NOT) ? 1'b0 : ir_q[5];
                    end else begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        illegal_q <= 1'b1;
                        dr_sel_q  <= 3'd0;
                        sr1_sel_q <= 3'd0;
                        sr2_sel_q <= 3'd0;
                    end
                end
                EXECUTE: begin
                    if (exec_cnt_q == 4'd0) begin
                        state_q  <= WRITEBACK;
                        ld_reg_q <= 1'b1;
                        ld_cc_q  <= 1'b1;
                    end else begin
                        exec_cnt_q <= exec_cnt_q - 4'd1;
                    end
                end
                WRITEBACK: begin
                    state_q   <= DONE;
                    done_q    <= 1'b1;
                    nzp_q     <= nzp_d;
                    ld_reg_q  <= 1'b0;
                    ld_cc_q   <= 1'b0;
                    aluk_q    <= ALUK_PASS;
                    sr2mux_q  <= 1'b0;
                    dr_sel_q  <= 3'd0;
                    sr1_sel_q <= 3'd0;
                    sr2_sel_q <= 3'd0;
                end
                DONE: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign ALUK    = aluk_q;
    assign SR2MUX  = sr2mux_q;
    assign SR1_SEL = sr1_sel_q;
    assign SR2_SEL = sr2_sel_q;
    assign DR_SEL  = dr_sel_q;
    assign LD_REG  = ld_reg_q;
    assign LD_CC   = ld_cc_q;
    assign NZP     = nzp_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a vector table of ALU ops checked cycle by
// cycle, plus reset-abort, held-start and EXEC_CYCLES=3 sequences.
module tb_alu_op_sequencer;
    import alu_ctrl_pkg::*;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] alu;
        logic [1:0]  aluk;
        logic        sr2mux;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic        ill;
        logic [2:0]  nzp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] ir;
    logic [15:0] alu_out;

    logic busy1, done1, ill1, sr2mux1, ldreg1, ldcc1;
    logic [1:0] aluk1;
    logic [2:0] dr1, sr11, sr21, nzp1;
    logic busy3, done3, ill3, sr2mux3, ldreg3, ldcc3;
    logic [1:0] aluk3;
    logic [2:0] dr3, sr13, sr23, nzp3;

    logic o_busy, o_done, o_ill, o_sr2mux, o_ldreg, o_ldcc;
    logic [1:0] o_aluk;
    logic [2:0] o_dr, o_sr1, o_sr2, o_nzp;
    logic sel3 = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    logic [2:0] nzp_m;
    vec_t vecs[7];

    always #5 clk = ~clk;

    alu_op_sequencer #(.EXEC_CYCLES(1)) dut1 (
        .Clk(clk), .Reset_n(rst_n), .start(start), .IR(ir), .ALU_OUT(alu_out),
        .busy(busy1), .done(done1), .illegal(ill1), .ALUK(aluk1), .SR2MUX(sr2mux1),
        .SR1_SEL(sr11), .SR2_SEL(sr21), .DR_SEL(dr1), .LD_REG(ldreg1), .LD_CC(ldcc1),
        .NZP(nzp1)
    );

    alu_op_sequencer #(.EXEC_CYCLES(3)) dut3 (
        .Clk(clk), .Reset_n(rst_n), .start(start), .IR(ir), .ALU_OUT(alu_out),
        .busy(busy3), .done(done3), .illegal(ill3), .ALUK(aluk3), .SR2MUX(sr2mux3),
        .SR1_SEL(sr13), .SR2_SEL(sr23), .DR_SEL(dr3), .LD_REG(ldreg3), .LD_CC(ldcc3),
        .NZP(nzp3)
    );

    always_comb begin
        o_busy = sel3 ? busy3 : busy1;
        o_done = sel3 ? done3 : done1;
        o_ill = sel3 ? ill3 : ill1;
        o_sr2mux = sel3 ? sr2mux3 : sr2mux1;
        o_ldreg = sel3 ? ldreg3 : ldreg1;
        o_ldcc = sel3 ? ldcc3 : ldcc1;
        o_aluk = sel3 ? aluk3 : aluk1;
        o_dr = sel3 ? dr3 : dr1;
        o_sr1 = sel3 ? sr13 : sr11;
        o_sr2 = sel3 ? sr23 : sr21;
        o_nzp = sel3 ? nzp3 : nzp1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_busy", 16'(o_busy), 16'(1'b0));
        chk("rst_done", 16'(o_done), 16'(1'b0));
        chk("rst_illegal", 16'(o_ill), 16'(1'b0));
        chk("rst_aluk", 16'(o_aluk), 16'(ALUK_PASS));
        chk("rst_sr2mux", 16'(o_sr2mux), 16'(1'b0));
        chk("rst_dr", 16'(o_dr), 16'(3'd0));
        chk("rst_sr1", 16'(o_sr1), 16'(3'd0));
        chk("rst_sr2", 16'(o_sr2), 16'(3'd0));
        chk("rst_ld_reg", 16'(o_ldreg), 16'(1'b0));
        chk("rst_ld_cc", 16'(o_ldcc), 16'(1'b0));
        chk("rst_nzp", 16'(o_nzp), 16'(3'b000));
    endtask

    // Cycle k counts from the accepting edge: DECODE=1, EXECUTE=2..1+e, WRITEBACK=2+e,
    // DONE=3+e (legal) or DONE=2 (illegal). Leaves the bench at cycle lat+1.
    task automatic run_op(input vec_t v, input int e, input bit hold);
        int lat;
        int wb;
        bit in_sel;
        bit in_alu;
        sel3 = (e == 3);
        lat = v.ill ? 2 : 3 + e;
        wb = 2 + e;
        @(negedge clk);
        ir = v.ir;
        alu_out = v.alu;
        start = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            in_sel = (k < lat);
            in_alu = !v.ill && (k >= 2) && (k <= wb);
            chk("busy", 16'(o_busy), 16'(1'b1));
            chk("dr_sel", 16'(o_dr), in_sel ? 16'(v.dr) : 16'd0);
            chk("sr1_sel", 16'(o_sr1), in_sel ? 16'(v.sr1) : 16'd0);
            chk("sr2_sel", 16'(o_sr2), in_sel ? 16'(v.sr2) : 16'd0);
            chk("aluk", 16'(o_aluk), in_alu ? 16'(v.aluk) : 16'(ALUK_PASS));
            chk("sr2mux", 16'(o_sr2mux), 16'(in_alu && v.sr2mux));
            chk("ld_reg", 16'(o_ldreg), 16'(!v.ill && k == wb));
            chk("ld_cc", 16'(o_ldcc), 16'(!v.ill && k == wb));
            chk("done", 16'(o_done), 16'(k == lat));
            chk("illegal", 16'(o_ill), 16'(v.ill && k == lat));
            if (e == 1)
                chk("nzp", 16'(o_nzp), (k == lat && !v.ill) ? 16'(v.nzp) : 16'(nzp_m));
            else if (k == lat)
                chk("nzp", 16'(o_nzp), 16'(v.nzp));
        end
        @(negedge clk);
        chk("idle_after_done", 16'(o_busy), 16'(1'b0));
        if (!v.ill && e == 1) nzp_m = v.nzp;
        $display("op ir=%h exec_cycles=%0d illegal=%0d done_cycle=%0d nzp=%b",
                 v.ir, e, v.ill, lat, o_nzp);
    endtask

    initial begin
        //          ir        alu       aluk       m     dr    sr1   sr2   ill   nzp
        vecs[0] = '{16'h1642, 16'h0005, ALUK_ADD, 1'b0, 3'd3, 3'd1, 3'd2, 1'b0, 3'b001};
        vecs[1] = '{16'h103F, 16'hFFFF, ALUK_ADD, 1'b1, 3'd0, 3'd0, 3'd7, 1'b0, 3'b100};
        vecs[2] = '{16'h5B60, 16'h0000, ALUK_AND, 1'b1, 3'd5, 3'd5, 3'd0, 1'b0, 3'b010};
        vecs[3] = '{16'h953F, 16'h1234, ALUK_NOT, 1'b0, 3'd2, 3'd4, 3'd7, 1'b0, 3'b001};
        vecs[4] = '{16'h2000, 16'h0000, ALUK_PASS, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'b000};
        vecs[5] = '{16'h5283, 16'h8000, ALUK_AND, 1'b0, 3'd1, 3'd2, 3'd3, 1'b0, 3'b100};
        vecs[6] = '{16'hF025, 16'h7FFF, ALUK_PASS, 1'b0, 3'd0, 3'd0, 3'd5, 1'b1, 3'b000};

        rst_n = 1'b0;
        start = 1'b0;
        ir = 16'h0;
        alu_out = 16'h0;
        nzp_m = 3'b000;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_op(vecs[i], 1, 1'b0);

        // Let the slower instance drain before exercising it
        repeat (12) @(negedge clk);
        run_op(vecs[2], 3, 1'b0);
        // The default instance executed the same AND with ALU_OUT=0
        nzp_m = 3'b010;
        sel3 = 1'b0;
        repeat (8) @(negedge clk);

        // start held high: one op, then a second only after IDLE (cycle 5 -> accepted)
        run_op(vecs[0], 1, 1'b1);
        for (int k = 6; k <= 9; k++) begin
            @(negedge clk);
            chk("hold_busy", 16'(o_busy), 16'(1'b1));
            chk("hold_done", 16'(o_done), 16'(k == 9));
        end
        start = 1'b0;
        $display("op ir=%h held start: second op done_cycle=9", vecs[0].ir);
        repeat (3) @(negedge clk);

        // Reset during EXECUTE aborts with no commit and no done
        ir = 16'h1642;
        alu_out = 16'h0005;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_in_execute", 16'(o_aluk), 16'(ALUK_ADD));
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_done", 16'(o_done), 16'(1'b0));
            chk("abort_no_ld_reg", 16'(o_ldreg), 16'(1'b0));
            chk("abort_no_ld_cc", 16'(o_ldcc), 16'(1'b0));
        end
        $display("op ir=1642 aborted by reset in EXECUTE");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multicycle control FSM that sequences the LC-3 ALU-class instructions: ADD (0001), AND (0101) and NOT (1001).
- Accepts an instruction word on a start handshake and decodes the register fields.
- Drives ALUK, SR2MUX and the register-file selects, then commits the result (LD_REG) and the condition codes (LD_CC and an internal NZP register).
- Sits between the fetch/decode sequencer and the ALU/register-file datapath.

Parameters:
- EXEC_CYCLES, 1, number of cycles spent in EXECUTE so the ALU result can settle; legal range 1..15.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- start  in  1  request to execute IR; sampled only in IDLE.
- IR  in  16  instruction word; captured on an accepted start.
- ALU_OUT  in  16  combinational ALU result, fed back for NZP generation.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse, coincident with done, for an unsupported opcode.
- ALUK  out  2  ALU function: 00 ADD, 01 AND, 11 NOT, 10 pass SR1.
- SR2MUX  out  1  0 selects the register operand, 1 selects sext(IR[4:0]).
- SR1_SEL  out  3  register-file read port 1 address.
- SR2_SEL  out  3  register-file read port 2 address.
- DR_SEL  out  3  register-file write address.
- LD_REG  out  1  register-file write enable.
- LD_CC  out  1  condition-code load strobe.
- NZP  out  3  condition codes {N,Z,P}, registered.

Behaviour:
- Reset (Reset_n=0 at a clock edge):
  - state := IDLE; ir_q := 0; NZP := 000; exec counter := 0.
  - All outputs 0, except ALUK = 10.
  - Reset takes priority in any state. An operation interrupted mid-flight produces no LD_REG, LD_CC or done.
- States: IDLE, DECODE, EXECUTE, WRITEBACK, DONE.
- IDLE:
  - On start=1, capture ir_q := IR and go to DECODE.
  - Otherwise stay in IDLE.
- DECODE:
  - Classify ir_q[15:12] and drive DR_SEL=ir_q[11:9], SR1_SEL=ir_q[8:6], SR2_SEL=ir_q[2:0].
  - Legal opcode: go to EXECUTE and load exec counter := EXEC_CYCLES-1.
  - Illegal opcode: go to DONE with an illegal flag set; LD_REG and LD_CC are never asserted.
- EXECUTE:
  - ALUK = 00 for ADD, 01 for AND, 11 for NOT.
  - SR2MUX = ir_q[5] for ADD/AND, 0 for NOT.
  - NOT ignores ir_q[5:0]; no check is made that it equals 111111.
  - Counter decrements each cycle. Move to WRITEBACK in the cycle the counter reads 0.
- WRITEBACK (exactly 1 cycle):
  - Same ALUK and SR2MUX as EXECUTE; LD_REG=1, LD_CC=1.
  - NZP loads at the end of this cycle from ALU_OUT:
    - N = ALU_OUT[15];
    - Z = (ALU_OUT == 0);
    - P = otherwise.
    - Result is always one-hot.
  - Next state DONE.
- DONE:
  - done=1 for one cycle; illegal=1 in the same cycle if flagged; next state IDLE.
  - The illegal flag clears on entering IDLE.
- Select and hold rules:
  - SR1_SEL, SR2_SEL and DR_SEL hold constant from DECODE through WRITEBACK. They are 0 in IDLE and DONE.
  - ALUK = 10 and SR2MUX = 0 outside EXECUTE/WRITEBACK.
- Latency for a legal op: start accepted at edge t, done high during cycle t+3+EXEC_CYCLES. With the default of 1, done is high 4 cycles after acceptance.
- Throughput: start is ignored while busy=1 and is not queued. A start asserted in the same cycle done is high is ignored, because the state is DONE, not IDLE.
- NZP holds its value across illegal ops and idle periods.
- No ALU arithmetic is performed here; widths are 16-bit throughout, with result wrap-around handled by the ALU.

Decomposition:
- Shared package alu_ctrl_pkg containing:
  - state enum (IDLE, DECODE, EXECUTE, WRITEBACK, DONE);
  - opcode constants OP_ADD=4'b0001, OP_AND=4'b0101, OP_NOT=4'b1001;
  - ALUK constants ALUK_ADD=2'b00, ALUK_AND=2'b01, ALUK_PASS=2'b10, ALUK_NOT=2'b11.
- One sub-module: nzp_gen, combinational; 16-bit value in, 3-bit one-hot NZP out. It is instantiated here and reused by the load/store sequencer.

Test Plan:
- ADD R3,R1,R2 (IR=16'h1642), start pulse; ALU_OUT model returns 16'h0005 → DR_SEL=3, SR1_SEL=1, SR2_SEL=2, ALUK=00, SR2MUX=0; LD_REG and LD_CC high in cycle 3; done in cycle 4; NZP=001.
- ADD R0,R0,#-1 (IR=16'h103F); ALU_OUT=16'hFFFF → SR2MUX=1, ALUK=00, NZP=100.
- AND R5,R5,#0 (IR=16'h5B60); ALU_OUT=0 → ALUK=01, SR2MUX=1, NZP=010. With EXEC_CYCLES=3, done moves to cycle 6.
- NOT R2,R4 (IR=16'h953F) → ALUK=11, SR2MUX=0, DR_SEL=2, SR1_SEL=4; NZP follows ALU_OUT.
- Illegal opcode (IR=16'h2000) → done and illegal high together in cycle 2; LD_REG and LD_CC never asserted; NZP unchanged.
- Reset_n low during EXECUTE → next cycle IDLE, all outputs at reset values, no done. Also: start held high through an ADD accepts only one op, and the next op is accepted only after IDLE is re-entered.
